adc0809_emu: RTL and testbench

//  Cycle-paced emulation of the ADC0809 8-channel converter that the Food Fight CPU polls for
//  the analog stick positions. Sits downstream of the stick sources: the real-analog/pseudo-analog
//  mux outputs (AX0/AY0/AX1/AY1) feed its channel inputs; the game core drives its ALE/START/OE

---
 rtl/adc0809_emu.sv | 134 +++++++++++++
 tb/tb_adc0809_emu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc0809_emu.sv
// adc0809_emu: cycle-paced ADC0809 converter emulation for the analog stick channels.
// Define ADC_SAR_EN for true successive approximation; default snapshots AIN at START fall.
module adc0809_emu #(
  parameter int unsigned CONV_TICKS = 64,
  parameter logic [7:0]  IDLE_VAL   = 8'hFF
) (
  input  logic        MCLK,
  input  logic        RST_N,
  input  logic        CEN,
  input  logic        ALE,
  input  logic        START,
  input  logic [2:0]  ADDR,
  input  logic        OE,
  input  logic [63:0] AIN,
  output logic [7:0]  DOUT,
  output logic        EOC,
  output logic        BUSY
);

  localparam int CW = $clog2(CONV_TICKS);
  localparam logic [CW-1:0] LAST = CW'(CONV_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    CONV
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    sar, sar_d;
  logic [7:0]    result, result_d;
  logic [2:0]    chan, chan_d;
  logic          eoc_d;
  logic          ale_q, ale_p;
  logic          start_q, start_p;
  logic          ale_rise;
  logic          start_rise;
  logic          start_fall;
  logic [7:0]    ain_sel;

  assign ale_rise   = ale_q & ~ale_p;
  assign start_rise = start_q & ~start_p;
  assign start_fall = ~start_q & start_p;
  assign ain_sel    = AIN[{chan, 3'b000} +: 8];

`ifdef ADC_SAR_EN
  localparam int STEP = CONV_TICKS / 8;
  logic [7:0] sar_step;

  // Bit k is decided against the live input at the end of its slot
  always_comb begin
    sar_step = sar;
    for (int k = 0; k < 8; k++) begin
      if (cnt == CW'((8 - k) * STEP - 1))
        sar_step[k] = ain_sel >= (sar | (8'd1 << k));
    end
  end
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sar_d    = sar;
    result_d = result;
    eoc_d    = EOC;
    chan_d   = ale_rise ? ADDR : chan;
    if (start_rise) begin
      state_d = CLR;
      eoc_d   = 1'b0;
      sar_d   = 8'h00;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: ;
        CLR: begin
          eoc_d = 1'b0;
          sar_d = 8'h00;
          cnt_d = '0;
          if (start_fall) begin
            state_d = CONV;
`ifndef ADC_SAR_EN
            sar_d = ain_sel;
`endif
          end
        end
        CONV: begin
          if (CEN) begin
`ifdef ADC_SAR_EN
            sar_d = sar_step;
`endif
            cnt_d = cnt + 1'b1;
            if (cnt == LAST) begin
              result_d = sar_d;
              eoc_d    = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      sar     <= 8'h00;
      result  <= 8'h00;
      chan    <= 3'd0;
      EOC     <= 1'b1;
      ale_q   <= 1'b0;
      ale_p   <= 1'b0;
      start_q <= 1'b0;
      start_p <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sar     <= sar_d;
      result  <= result_d;
      chan    <= chan_d;
      EOC     <= eoc_d;
      ale_q   <= ALE;
      ale_p   <= ale_q;
      start_q <= START;
      start_p <= start_q;
    end
  end

  assign BUSY = (state == CONV);
  assign DOUT = OE ? result : IDLE_VAL;

endmodule

// File: tb/tb_adc0809_emu.sv
// tb_adc0809_emu: directed bench for adc0809_emu with a behavioural converter model.
// A second instance with an 8-tick conversion checks the short-conversion boundary.
module tb_adc0809_emu;

  localparam int T = 64;

  logic        MCLK  = 1'b0;
  logic        RST_N = 1'b0;
  logic        CEN   = 1'b0;
  logic        ALE   = 1'b0;
  logic        START = 1'b0;
  logic        OE    = 1'b0;
  logic [2:0]  ADDR  = 3'd0;
  logic [63:0] AIN   = {8{8'h80}};
  logic [7:0]  DOUT, dout8;
  logic        EOC, BUSY, eoc8, busy8;

  int checks = 0;
  int errors = 0;

  adc0809_emu #(.CONV_TICKS(T), .IDLE_VAL(8'hFF)) u_dut (
    .MCLK(MCLK), .RST_N(RST_N), .CEN(CEN), .ALE(ALE), .START(START),
    .ADDR(ADDR), .OE(OE), .AIN(AIN), .DOUT(DOUT), .EOC(EOC), .BUSY(BUSY)
  );

  adc0809_emu #(.CONV_TICKS(8), .IDLE_VAL(8'hFF)) u_dut8 (
    .MCLK(MCLK), .RST_N(RST_N), .CEN(CEN), .ALE(ALE), .START(START),
    .ADDR(ADDR), .OE(OE), .AIN(AIN), .DOUT(dout8), .EOC(eoc8), .BUSY(busy8)
  );

  always #5 MCLK = ~MCLK;

  // One CEN pulse every third MCLK
  int cdiv = 0;
  initial forever begin
    @(posedge MCLK);
    #2;
    cdiv = (cdiv + 1) % 3;
    CEN = (cdiv == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: sampled strobes, pending/active flags, per-tick input history
  logic       st1 = 0, st0 = 0, a1 = 0, a0 = 0;
  logic       pend = 0, act = 0, m_eoc = 1;
  logic [7:0] m_res = 8'h00, snap = 8'h00, live;
  logic [2:0] mchan = 3'd0;
  int         ticks = 0;
  logic [7:0] hist [T];

  function automatic logic [7:0] conv_result();
`ifdef ADC_SAR_EN
    logic [7:0] r;
    r = 8'h00;
    for (int k = 7; k >= 0; k--)
      if (hist[(8 - k) * (T / 8) - 1] >= (r | 8'(1 << k))) r[k] = 1'b1;
    return r;
`else
    return snap;
`endif
  endfunction

  initial forever begin
    @(posedge MCLK or negedge RST_N);
    if (!RST_N) begin
      st1 = 0; st0 = 0; a1 = 0; a0 = 0;
      pend = 0; act = 0; m_eoc = 1; m_res = 8'h00;
      mchan = 3'd0; ticks = 0;
    end else begin
      live = AIN[8*mchan +: 8];
      if (a1 && !a0) mchan = ADDR;
      if (st1 && !st0) begin
        pend = 1; act = 0; m_eoc = 0;
      end else if (pend && !st1 && st0) begin
        pend = 0; act = 1; ticks = 0; snap = live;
      end else if (act && CEN) begin
        hist[ticks] = live;
        ticks++;
        if (ticks == T) begin
          m_res = conv_result();
          m_eoc = 1; act = 0;
        end
      end
      st0 = st1; st1 = START;
      a0 = a1; a1 = ALE;
    end
  end

  initial forever begin
    @(negedge MCLK);
    chk("eoc", EOC, m_eoc);
    chk("busy", BUSY, act);
    chk("dout", DOUT, OE ? m_res : 8'hFF);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge MCLK);
    #2;
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    AIN[8*c +: 8] = v;
  endtask

  task automatic sel(input logic [2:0] a);
    ADDR = a; ALE = 1'b1;
    tick(2);
    ALE = 1'b0;
    tick(2);
  endtask

  task automatic pulse_start(input logic eoc_before);
    START = 1'b1;
    @(posedge MCLK); #1;
    chk("eoc_pre", EOC, eoc_before);
    @(posedge MCLK); #1;
    chk("eoc_fall", EOC, 1'b0);
    #1;
    START = 1'b0;
    @(posedge MCLK);
    @(posedge MCLK);
  endtask

  // Count CEN ticks until EOC rises or stop_at is reached; bounded
  task automatic count(input int stop_at, input int flip_at, input int fch,
                       input logic [7:0] fval, output int n, output int n8);
    n = 0;
    n8 = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge MCLK);
      if (CEN) n++;
      #1;
      if (n8 < 0 && eoc8) n8 = n;
      if (n == flip_at) AIN[8*fch +: 8] = fval;
      if (EOC || n == stop_at) break;
    end
    #1;
  endtask

  task automatic read(input string nm, input logic [7:0] exp);
    OE = 1'b1; #1;
    chk(nm, DOUT, exp);
    OE = 1'b0; #1;
    chk({nm, "_idle"}, DOUT, 8'hFF);
  endtask

  int n, n8;
  logic [7:0] sar_exp;

  initial begin
    tick(3);
    chk("rst_eoc", EOC, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_dout_idle", DOUT, 8'hFF);
    OE = 1'b1; #1;
    chk("rst_dout_oe", DOUT, 8'h00);
    OE = 1'b0;
    RST_N = 1'b1;
    tick(3);

    set_ch(2, 8'h5A);
    sel(3'd2);
    pulse_start(1'b1);
    count(-1, -1, 0, 8'h00, n, n8);
    chk("basic_ticks", n, T);
    chk("short_ticks", n8, 8);
    chk("model_pin", m_res, 8'h5A);
    read("basic", 8'h5A);
    OE = 1'b1; #1;
    chk("short_dout", dout8, 8'h5A);
    OE = 1'b0;
    tick(2);

    set_ch(0, 8'h10);
    set_ch(7, 8'hF0);
    sel(3'd0);
    pulse_start(1'b1);
    count(-1, -1, 0, 8'h00, n, n8);
    read("ch0", 8'h10);
    sel(3'd7);
    pulse_start(1'b1);
    count(-1, -1, 0, 8'h00, n, n8);
    read("ch7", 8'hF0);

    sel(3'd2);
    pulse_start(1'b1);
    count(-1, -1, 0, 8'h00, n, n8);
    read("pre_abort", 8'h5A);
    set_ch(2, 8'h33);
    pulse_start(1'b1);
    count(30, -1, 0, 8'h00, n, n8);
    chk("abort_at", n, 30);
    chk("abort_eoc", EOC, 1'b0);
    read("abort_hold", 8'h5A);
    pulse_start(1'b0);
    count(-1, -1, 0, 8'h00, n, n8);
    chk("restart_ticks", n, T);
    read("restart", 8'h33);

    set_ch(3, 8'h00);
    sel(3'd3);
    pulse_start(1'b1);
    count(-1, T / 8, 3, 8'hFF, n, n8);
`ifdef ADC_SAR_EN
    sar_exp = 8'h7F;
`else
    sar_exp = 8'h00;
`endif
    read("sar_mix", sar_exp);

    set_ch(4, 8'h00);
    set_ch(5, 8'hFF);
    sel(3'd4);
    pulse_start(1'b1);
    count(-1, -1, 0, 8'h00, n, n8);
    read("zero", 8'h00);
    sel(3'd5);
    pulse_start(1'b1);
    count(-1, -1, 0, 8'h00, n, n8);
    read("full", 8'hFF);

    sel(3'd2);
    pulse_start(1'b1);
    count(20, -1, 0, 8'h00, n, n8);
    chk("mid_busy", BUSY, 1'b1);
    OE = 1'b1;
    RST_N = 1'b0; #1;
    chk("mid_rst_eoc", EOC, 1'b1);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_dout", DOUT, 8'h00);
    OE = 1'b0; #1;
    chk("mid_rst_idle", DOUT, 8'hFF);
    tick(2);
    RST_N = 1'b1;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
